// File: rtl/t05_sd_block_rx.sv
// t05_sd_block_rx: SD multi-block read receiver with token hunt, FIFO output and CRC check.
// Define T05_BLOCK_RX_CRC_EN to build the CRC16-CCITT data check.
module t05_sd_block_rx #(
  parameter int FIFO_DEPTH    = 4,
  parameter int TOKEN_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] num_blocks,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_req,
  output logic       read_stop,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       busy,
  output logic       done,
  output logic       timeout_err,
  output logic       crc_err,
  output logic [7:0] block_idx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int HW = $clog2(TOKEN_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, HUNT, DATA, CRC_HI, CRC_LO, STOP} state_t;
  state_t        state_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic [HW-1:0] hunt_q;
  logic [8:0]    bcnt_q;
  logic [7:0]    nb_q, idx_q;
  logic          pend_q, req_q, stop_q, done_q, tout_q;
  logic          take, push, pop, full, can_req;
  assign take       = pend_q & byte_valid;
  assign push       = take & (state_q == DATA);
  assign pop        = (cnt_q != '0) & data_ready;
  assign full       = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign cnt_d      = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  // a new request only goes out once the previous byte has landed and there is room for it
  assign can_req    = (state_q != IDLE) & (state_q != STOP) & ~pend_q & ~full;
  assign byte_req   = req_q;
  assign read_stop  = stop_q;
  assign done       = done_q;
  assign timeout_err = tout_q;
  assign block_idx  = idx_q;
  assign busy       = state_q != IDLE;
  assign data_valid = cnt_q != '0;
  assign data_out   = data_valid ? mem_q[rd_q] : 8'h00;
  always_ff @(posedge clk) if (push) mem_q[wr_q] <= byte_in;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= push ? wr_q + AW'(1) : wr_q;
      rd_q  <= pop ? rd_q + AW'(1) : rd_q;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      req_q   <= 1'b0;
      stop_q  <= 1'b0;
      done_q  <= 1'b0;
      tout_q  <= 1'b0;
      hunt_q  <= '0;
      bcnt_q  <= '0;
      nb_q    <= '0;
      idx_q   <= '0;
    end else begin
      req_q  <= can_req;
      done_q <= 1'b0;
      pend_q <= can_req ? 1'b1 : take ? 1'b0 : pend_q;
      case (state_q)
        IDLE: if (start) begin
          if (num_blocks != 8'd0) begin
            nb_q    <= num_blocks;
            idx_q   <= '0;
            tout_q  <= 1'b0;
            hunt_q  <= '0;
            state_q <= HUNT;
          end else done_q <= 1'b1;
        end
        HUNT: if (take) begin
          if (byte_in == 8'hFE) begin
            hunt_q  <= '0;
            state_q <= DATA;
          end else begin
            hunt_q <= hunt_q + HW'(byte_in == 8'hFF);
            if (byte_in != 8'hFF || hunt_q == HW'(TOKEN_TIMEOUT - 1)) begin
              tout_q  <= 1'b1;
              stop_q  <= 1'b1;
              state_q <= STOP;
            end
          end
        end
        DATA: if (take) begin
          bcnt_q <= bcnt_q + 9'd1;
          if (&bcnt_q) state_q <= CRC_HI;
        end
        CRC_HI: if (take) state_q <= CRC_LO;
        CRC_LO: if (take) begin
          idx_q <= idx_q + 8'd1;
          if (idx_q + 8'd1 == nb_q) begin
            stop_q  <= 1'b1;
            state_q <= STOP;
          end else state_q <= HUNT;
        end
        STOP: if (cnt_q == '0) begin
          stop_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef T05_BLOCK_RX_CRC_EN
  logic [15:0] crc_q;
  logic [7:0]  hi_q;
  logic        cerr_q;
  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? {r[14:0], 1'b0} ^ 16'h1021 : {r[14:0], 1'b0};
    return r;
  endfunction
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q  <= '0;
      hi_q   <= '0;
      cerr_q <= 1'b0;
    end else begin
      if (state_q == IDLE && start && num_blocks != 8'd0) cerr_q <= 1'b0;
      if (state_q == HUNT) crc_q <= '0;
      if (push) crc_q <= crc_upd(crc_q, byte_in);
      if (take && state_q == CRC_HI) hi_q <= byte_in;
      if (take && state_q == CRC_LO && crc_q != {hi_q, byte_in}) cerr_q <= 1'b1;
    end
  end
  assign crc_err = cerr_q;
`else
  assign crc_err = 1'b0;
`endif
endmodule
